// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and width helpers for the FIR MAC sequencer
package fir_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_TAPS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_e;

    // Full product plus enough headroom to sum TAPS of them without overflow.
    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample, result and coefficient ports of the FIR engine
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int TAPS   = DEFAULT_TAPS
);
    localparam int ACC_W = acc_width(DATA_W, TAPS);
    localparam int AW    = $clog2(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [DATA_W-1:0] coef_wdata;
    logic                     coef_err;
    logic                     flush;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, flush,
        input  in_ready, out_valid, out_data, coef_err, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, flush,
        output in_ready, out_valid, out_data, coef_err, busy
    );

endinterface

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - sample delay line with write pointer and tap read port
module fir_sample_ring #(
    parameter  int DATA_W = 16,
    parameter  int TAPS   = 8,
    localparam int AW     = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     advance,
    input  logic                     flush,
    input  logic [AW-1:0]            rd_k,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] ring_q [TAPS];
    logic signed [DATA_W-1:0] ring_d [TAPS];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]              rd_idx;

    // x[n-k] lives k slots behind the newest sample; wrap without relying on 2^AW == TAPS.
    assign rd_idx  = (wr_ptr_q >= rd_k) ? ({1'b0, wr_ptr_q} - {1'b0, rd_k})
                                        : ({1'b0, wr_ptr_q} + (AW+1)'(TAPS) - {1'b0, rd_k});
    assign rd_data = ring_q[rd_idx[AW-1:0]];

    always_comb begin
        ring_d   = ring_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            for (int i = 0; i < TAPS; i++) ring_d[i] = '0;
            wr_ptr_d = '0;
        end else begin
            if (wr_en) ring_d[wr_ptr_q] = wr_data;
            if (advance) wr_ptr_d = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) ring_q[i] <= '0;
            wr_ptr_q <= '0;
        end else begin
            ring_q   <= ring_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR engine, one multiply-accumulate per tap per cycle
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int TAPS   = DEFAULT_TAPS
) (
    input logic                clk,
    input logic                rst,
    fir_mac_sequencer_if.slave bus
);

    localparam int ACC_W = acc_width(DATA_W, TAPS);
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = 2 * DATA_W;

    state_e                   state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  out_data_q, out_data_d;
    logic signed [PW-1:0]     prod_q, prod_d;
    logic                     out_valid_q, out_valid_d;
    logic                     coef_err_q, coef_err_d;
    logic signed [DATA_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] coef_d [TAPS];

    logic                     accept;
    logic                     coef_ok;
    logic                     idle;
    logic signed [DATA_W-1:0] tap_sample;
    logic signed [PW-1:0]     tap_ext, coef_ext;
    logic signed [ACC_W-1:0]  acc_sum;

    fir_sample_ring #(
        .DATA_W(DATA_W),
        .TAPS  (TAPS)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .wr_data(bus.in_data),
        .advance(state_q == DRAIN),
        .flush  (idle && bus.flush),
        .rd_k   (k_q),
        .rd_data(tap_sample)
    );

    assign idle     = (state_q == IDLE);
    assign accept   = bus.in_valid && bus.in_ready;
    assign coef_ok  = bus.coef_we && idle && ({1'b0, bus.coef_addr} < (AW+1)'(TAPS));
    assign tap_ext  = PW'(tap_sample);
    assign coef_ext = PW'(coef_q[k_q]);
    assign acc_sum  = acc_q + ACC_W'(prod_q);

    assign bus.in_ready  = idle && !bus.flush;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.coef_err  = coef_err_q;
    assign bus.busy      = !idle;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        coef_d      = coef_q;
        coef_err_d  = bus.coef_we && !coef_ok;

        // Lands before the MAC reads it, so a same-cycle accept sees the new coefficient.
        if (coef_ok) coef_d[bus.coef_addr] = bus.coef_wdata;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                prod_d = tap_ext * coef_ext;
                // prod_q still holds the previous sample's last product on k=0.
                if (k_q != '0) acc_d = acc_sum;
                if (k_q == AW'(TAPS - 1)) state_d = DRAIN;
                else                      k_d     = k_q + 1'b1;
            end
            DRAIN: begin
                acc_d       = acc_sum;
                out_data_d  = acc_sum;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            coef_err_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            coef_err_q  <= coef_err_d;
            coef_q      <= coef_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int DATA_W = 16;
    localparam int TAPS   = 8;
    localparam int LAT    = TAPS + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.DATA_W(DATA_W), .TAPS(TAPS)) bus ();

    fir_mac_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        longint y;
        int     edge_no;
    } exp_t;

    typedef struct {
        logic signed [DATA_W-1:0] x;
        longint                   y;
    } vec_t;

    exp_t   sb[$];
    vec_t   vecs[8];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    longint mh[TAPS];
    longint mx[TAPS];
    logic   prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout/unexpected event expected normal completion", name);
    endtask

    function automatic longint od();
        return longint'(bus.out_data);
    endfunction

    // Scoreboard: shift-register reference model, sampled half a cycle before each edge.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin mh[i] = 0; mx[i] = 0; end
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) fail("unexpected_out_valid");
                else chk("latency", cyc, sb[0].edge_no + LAT);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) fail("scoreboard_underflow");
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_out_data", od(), e.y);
                end
            end
            prev_ov = bus.out_valid;
            if (bus.coef_we && !bus.busy) mh[bus.coef_addr] = longint'(bus.coef_wdata);
            if (bus.flush && !bus.busy) begin
                for (int i = 0; i < TAPS; i++) mx[i] = 0;
            end else if (bus.in_valid && !bus.busy) begin
                exp_t e;
                for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
                mx[0] = longint'(bus.in_data);
                e.y = 0;
                for (int i = 0; i < TAPS; i++) e.y += mh[i] * mx[i];
                e.edge_no = cyc + 1;
                sb.push_back(e);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        if (bus.busy) fail(name);
    endtask

    task automatic send_sample(input logic signed [DATA_W-1:0] x);
        int n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.in_ready) fail("in_ready_timeout");
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic signed [DATA_W-1:0] val,
                              output logic err, output logic err_next);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = addr[2:0];
        bus.coef_wdata = val;
        @(negedge clk);
        bus.coef_we = 1'b0;
        #1 err = bus.coef_err;
        @(negedge clk);
        #1 err_next = bus.coef_err;
    endtask

    task automatic load_all(input logic signed [DATA_W-1:0] v0, input logic signed [DATA_W-1:0] rest);
        logic e0, e1;
        for (int i = 0; i < TAPS; i++) write_coef(i, (i == 0) ? v0 : rest, e0, e1);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic e0, e1;
        int   n;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.flush      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", od(), 0);
        chk("rst_coef_err", bus.coef_err, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Impulse response against a hand-written table.
        vecs[0] = '{16'sd1, 1}; vecs[1] = '{16'sd0, 2}; vecs[2] = '{16'sd0, 3}; vecs[3] = '{16'sd0, 4};
        vecs[4] = '{16'sd0, 0}; vecs[5] = '{16'sd0, 0}; vecs[6] = '{16'sd0, 0}; vecs[7] = '{16'sd0, 0};
        write_coef(0, 16'sd1, e0, e1);
        write_coef(1, 16'sd2, e0, e1);
        write_coef(2, 16'sd3, e0, e1);
        write_coef(3, 16'sd4, e0, e1);
        for (int i = 4; i < TAPS; i++) write_coef(i, 16'sd0, e0, e1);
        chk("coef_write_ok", e0, 0);
        for (int i = 0; i < 8; i++) begin
            send_sample(vecs[i].x);
            wait_idle("impulse_idle");
            chk("impulse_out", od(), vecs[i].y);
        end

        // Extreme values: 8 * (-32768)^2 must not wrap.
        load_all(-16'sd32768, -16'sd32768);
        for (int i = 0; i < 8; i++) begin
            send_sample(-16'sd32768);
            wait_idle("extreme_idle");
        end
        chk("extreme_out", od(), 64'sd8589934592);

        // Backpressure: result held, no new sample accepted.
        bus.out_ready = 1'b0;
        send_sample(16'sd1);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        if (!bus.out_valid) fail("bp_out_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_data", od(), 64'sd7516160000);
            chk("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1);

        // Coefficient write while busy is rejected, accepted once idle.
        load_all(16'sd1, 16'sd0);
        pulse_flush();
        send_sample(16'sd3);
        write_coef(2, 16'sd100, e0, e1);
        chk("busy_write_err", e0, 1);
        chk("busy_write_err_pulse", e1, 0);
        wait_idle("rej_idle");
        chk("rej_out", od(), 3);
        write_coef(2, 16'sd100, e0, e1);
        chk("idle_write_err", e0, 0);
        send_sample(16'sd0);
        wait_idle("rej_idle2");
        send_sample(16'sd0);
        wait_idle("rej_idle3");
        chk("new_coef_used", od(), 300);

        // Flush clears the ring; flush beats a simultaneous sample.
        load_all(16'sd1, 16'sd1);
        for (int i = 0; i < 5; i++) begin
            send_sample(16'sd5);
            wait_idle("flush_fill_idle");
        end
        pulse_flush();
        send_sample(16'sd5);
        wait_idle("flush_refill_idle");
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd9;
        #1 chk("flush_blocks_in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1 chk("flush_no_accept", bus.busy, 0);
        send_sample(16'sd1);
        wait_idle("flush_idle");
        chk("flush_out", od(), 1);

        // Reset during MAC cycle 3 discards everything.
        send_sample(16'sd7);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", od(), 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_all(16'sd1, 16'sd1);
        send_sample(16'sd1);
        wait_idle("postrst_idle");
        chk("postrst_out", od(), 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
